// File: rtl/rf_pkg.sv
// Shared constants for the register-file write-back path.
//   RF_NREG / RF_AWIDTH : register count and address width
//   NREQ_DEFAULT        : default number of write-back requesters
//   REQ_ALU/LSU/MDU     : requester slot indices
package rf_pkg;

    localparam int unsigned RF_NREG      = 32;
    localparam int unsigned RF_AWIDTH    = 5;
    localparam int unsigned NREQ_DEFAULT = 3;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_LSU = 1;
    localparam int unsigned REQ_MDU = 2;

    // Width of an index into n requesters (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: searches ptr, ptr+1, ... wrapping at NREQ, grants first set req.
//   req_i     : request vector
//   ptr_i     : highest-priority index for this cycle (must be < NREQ)
//   gnt_o     : one-hot grant, zero when no request
//   gnt_idx_o : index of the granted requester (0 when no grant)
module rr_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    localparam int unsigned PW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   gnt_idx_o
);

    localparam int unsigned SW = PW + 1;

    logic [SW-1:0] sum;
    logic [PW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        sum       = '0;
        idx       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_i} + SW'(k);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            idx = sum[PW-1:0];
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates NREQ write-back requesters onto one register-file write port.
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/addr/data : packed per-requester write-back requests
//   req_ready         : combinational one-hot grant (accept = valid & ready)
//   wr/wraddr/din     : registered register-file write port
//   pend_*            : mirror of the write port for decode-stage bypass
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned NREQ   = NREQ_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [RF_AWIDTH*NREQ-1:0] req_addr,
    input  logic [DWIDTH*NREQ-1:0]    req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      wr,
    output logic [RF_AWIDTH-1:0]      wraddr,
    output logic [DWIDTH-1:0]         din,
    output logic                      pend_valid,
    output logic [RF_AWIDTH-1:0]      pend_addr,
    output logic [DWIDTH-1:0]         pend_data
);

    localparam int unsigned PW = idx_width(NREQ);

    logic [PW-1:0]        ptr_q, ptr_d;
    logic                 wr_q, wr_d;
    logic [RF_AWIDTH-1:0] wraddr_q, wraddr_d;
    logic [DWIDTH-1:0]    din_q, din_d;

    logic [NREQ-1:0]      req_live;
    logic [NREQ-1:0]      gnt;
    logic [PW-1:0]        gnt_idx;
    logic [RF_AWIDTH-1:0] sel_addr;
    logic [DWIDTH-1:0]    sel_data;

    // Nothing is granted while reset is held.
    assign req_live = rst ? '0 : req_valid;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i     (req_live),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign req_ready = gnt;

    // Payload of the granted requester (one-hot OR mux).
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = sel_addr | req_addr[i*RF_AWIDTH +: RF_AWIDTH];
                sel_data = sel_data | req_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    // Next state: advance pointer past the winner; zero-register writes are dropped.
    always_comb begin
        ptr_d    = ptr_q;
        wr_d     = 1'b0;
        wraddr_d = wraddr_q;
        din_d    = din_q;
        if (|gnt) begin
            ptr_d    = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
            wr_d     = (sel_addr != '0);
            wraddr_d = sel_addr;
            din_d    = sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            wr_q     <= 1'b0;
            wraddr_q <= '0;
            din_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            wr_q     <= wr_d;
            wraddr_q <= wraddr_d;
            din_q    <= din_d;
        end
    end

    // Reset blanks the port in its own cycle, so a write accepted just before reset is dropped.
    assign wr         = wr_q & ~rst;
    assign wraddr     = rst ? '0 : wraddr_q;
    assign din        = rst ? '0 : din_q;
    assign pend_valid = wr;
    assign pend_addr  = wraddr;
    assign pend_data  = din;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 3;
    localparam int unsigned AW = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [AW*NR-1:0] req_addr  = '0;
    logic [DW*NR-1:0] req_data  = '0;
    logic [NR-1:0]    req_ready;
    logic             wr;
    logic [AW-1:0]    wraddr;
    logic [DW-1:0]    din;
    logic             pend_valid;
    logic [AW-1:0]    pend_addr;
    logic [DW-1:0]    pend_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DWIDTH(DW), .NREQ(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .wr         (wr),
        .wraddr     (wraddr),
        .din        (din),
        .pend_valid (pend_valid),
        .pend_addr  (pend_addr),
        .pend_data  (pend_data)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    int            m_ptr   = 0;
    logic          m_wr    = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_data  = '0;
    bit            m_known = 1'b1;
    logic [DW-1:0] m_rf [32];
    wr_t           sb [$];
    int            wait_cnt [NR];
    logic [NR-1:0] acc_last = '0;

    always @(negedge clk) begin
        logic [NR-1:0] eg;
        int            g;
        int            idx;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        wr_t           e;

        // Outputs for this cycle
        if (rst) begin
            chk("rst_wr", 64'(wr), 64'h0);
            chk("rst_pend_valid", 64'(pend_valid), 64'h0);
            chk("rst_wraddr", 64'(wraddr), 64'h0);
            chk("rst_din", 64'(din), 64'h0);
        end else begin
            chk("wr", 64'(wr), 64'(m_wr));
            chk("pend_valid", 64'(pend_valid), 64'(m_wr));
            if (m_known) begin
                chk("wraddr", 64'(wraddr), 64'(m_addr));
                chk("din", 64'(din), 64'(m_data));
            end
            chk("pend_addr", 64'(pend_addr), 64'(wraddr));
            chk("pend_data", 64'(pend_data), 64'(din));
            if (m_wr) m_rf[m_addr] = m_data;
            if (wr) begin
                if (sb.size() == 0) begin
                    chk("sb_extra_write", 64'h1, 64'h0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_addr", 64'(wraddr), 64'(e.a));
                    chk("sb_data", 64'(din), 64'(e.d));
                end
            end
        end

        // Expected grant: first valid requester starting at the pointer
        eg = '0;
        g  = -1;
        if (!rst) begin
            for (int k = 0; k < NR; k++) begin
                idx = (m_ptr + k) % NR;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(eg));
        acc_last = req_valid & req_ready;

        // Starvation bound on the DUT's own grants
        for (int i = 0; i < NR; i++) begin
            if (!rst && req_valid[i] && !req_ready[i]) begin
                wait_cnt[i]++;
                chk("starve", 64'(wait_cnt[i] <= NR - 1), 64'h1);
            end else begin
                wait_cnt[i] = 0;
            end
        end

        // Advance model to next cycle
        if (rst) begin
            m_ptr   = 0;
            m_wr    = 1'b0;
            m_addr  = '0;
            m_data  = '0;
            m_known = 1'b1;
            sb.delete();
        end else if (g >= 0) begin
            ga      = req_addr[g*AW +: AW];
            gd      = req_data[g*DW +: DW];
            m_ptr   = (g + 1) % NR;
            m_wr    = (ga != '0);
            m_known = (ga != '0);
            m_addr  = ga;
            m_data  = gd;
            if (ga != '0) sb.push_back('{a: ga, d: gd});
        end else begin
            m_wr = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset, with requests present during reset
        rst = 1'b1;
        req_valid = '0;
        tick();
        tick();
        req_valid = 3'b111;
        @(negedge clk);
        chk("reset_ready", 64'(req_ready), 64'h0);
        chk("reset_wr", 64'(wr), 64'h0);
        tick();

        // Single request on the load unit
        rst = 1'b0;
        set_req(0, 1'b0, 5'd0, 32'h0);
        set_req(1, 1'b1, 5'd7, 32'hDEADBEEF);
        set_req(2, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("lsu_ready", 64'(req_ready), 64'h2);
        chk("post_reset_wr", 64'(wr), 64'h0);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("lsu_wr", 64'(wr), 64'h1);
        chk("lsu_wraddr", 64'(wraddr), 64'h7);
        chk("lsu_din", 64'(din), 64'hDEADBEEF);
        tick();

        // All three held valid after a fresh reset: 0,1,2,0,1,2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1'b1, 5'd1, 32'h100);
        set_req(1, 1'b1, 5'd2, 32'h200);
        set_req(2, 1'b1, 5'd3, 32'h300);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rr_order", 64'(req_ready), 64'(3'b001 << (c % 3)));
            if (c > 0) chk("rr_no_bubble", 64'(wr), 64'h1);
            tick();
        end
        req_valid = '0;
        @(negedge clk);
        chk("rr_last_wr", 64'(wr), 64'h1);
        chk("rr_last_addr", 64'(wraddr), 64'h3);
        chk("rr_last_din", 64'(din), 64'h300);
        tick();

        // Write to the zero register is consumed but never written
        set_req(0, 1'b1, 5'd0, 32'h1234);
        @(negedge clk);
        chk("zero_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("zero_wr", 64'(wr), 64'h0);
        tick();

        // Move pointer to 2, then same-address collision between 0 and 2
        set_req(1, 1'b1, 5'd9, 32'h99);
        @(negedge clk);
        chk("ptr_move_ready", 64'(req_ready), 64'h2);
        tick();
        set_req(1, 1'b0, 5'd0, 32'h0);
        set_req(0, 1'b1, 5'd5, 32'hA);
        set_req(2, 1'b1, 5'd5, 32'hB);
        @(negedge clk);
        chk("coll_first", 64'(req_ready), 64'h4);
        tick();
        set_req(2, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("coll_second", 64'(req_ready), 64'h1);
        chk("coll_din_b", 64'(din), 64'hB);
        chk("coll_addr_b", 64'(wraddr), 64'h5);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("coll_din_a", 64'(din), 64'hA);
        tick();
        @(negedge clk);
        chk("model_r5", 64'(m_rf[5]), 64'hA);
        tick();

        // Reset right after an acceptance suppresses that write
        set_req(0, 1'b1, 5'd4, 32'h44);
        @(negedge clk);
        chk("pre_rst_ready", 64'(req_ready), 64'h1);
        tick();
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        chk("suppressed_wr", 64'(wr), 64'h0);
        chk("suppressed_pend", 64'(pend_valid), 64'h0);
        tick();
        rst = 1'b0;
        set_req(2, 1'b1, 5'd6, 32'h66);
        @(negedge clk);
        chk("post_rst_mdu_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("post_rst_mdu_wr", 64'(wr), 64'h1);
        chk("post_rst_mdu_addr", 64'(wraddr), 64'h6);
        tick();

        // Random traffic obeying hold-until-accepted
        repeat (10000) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] || acc_last[i]) begin
                    if ($urandom_range(0, 3) != 0)
                        set_req(i, 1'b1, 5'($urandom_range(0, 31)), $urandom);
                    else
                        set_req(i, 1'b0, 5'd0, 32'h0);
                end
            end
            tick();
        end
        req_valid = '0;
        tick();
        tick();
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
